mux_scan_ctrl: RTL and testbench

- Upstream sequencer for the 65536:1 bit-select mux: drives its 16-bit select, samples its 1-bit output, and packs consecutive samples into words.
- Scans a window of `len` addresses starting at `base`.
- Packs bits LSB-first into WORD_W-bit words and emits them on a valid/ready stream with a last flag.
- Used to read out the wide bit vector feeding the mux as a compact word stream.

---
 rtl/mux_scan_pkg.sv | 20 ++
 rtl/mux_scan_packer.sv | 81 ++++++++
 rtl/mux_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared state encoding and sizing helpers for the mux scan controller.
// Optional parity output is enabled with the MUX_SCAN_PARITY_EN macro.
package mux_scan_pkg;

    localparam int SEL_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EMIT,
        ST_DONE
    } scan_state_e;

    // Width needed to count 0..word_w filled bit slots.
    function automatic int bitcnt_width(input int word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/mux_scan_packer.sv
// LSB-first bit packer: shift register, fill counter and word-full flag.
// With MUX_SCAN_PARITY_EN defined it also tracks the XOR of the packed bits.
module mux_scan_packer
    import mux_scan_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_bit,
    input  logic              clr,
    output logic [WORD_W-1:0] word,
    output logic              fill_last
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic              parity
`endif
);

    localparam int BCW = bitcnt_width(WORD_W);
    localparam logic [BCW-1:0] LAST_SLOT = BCW'(WORD_W - 1);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]    bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0] slot_hit;

    // One-hot write strobe for the slot addressed by the fill counter.
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_slot
        assign slot_hit[gi] = wr_en && (bitcnt_q == BCW'(gi));
    end

    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        if (clr) begin
            shreg_d  = '0;
            bitcnt_d = '0;
        end else if (wr_en) begin
            shreg_d  = (shreg_q & ~slot_hit) | (slot_hit & {WORD_W{wr_bit}});
            bitcnt_d = bitcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    assign word      = shreg_q;
    assign fill_last = (bitcnt_q == LAST_SLOT);

`ifdef MUX_SCAN_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (clr) begin
            parity_d = 1'b0;
        end else if (wr_en) begin
            parity_d = parity_q ^ wr_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a wide bit-select mux: walks sel over [base, base+len), samples y, streams packed words.
// Define MUX_SCAN_PARITY_EN to add the out_parity output.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SEL_W  = SEL_W_DEFAULT,
    parameter int WORD_W = 8,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SEL_W-1:0]  base,
    input  logic [SEL_W:0]    len,
    output logic [SEL_W-1:0]  sel,
    input  logic              y,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam logic [3:0]  SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
    // Where to go whenever the next bit is due: straight to SAMPLE when no settling is needed.
    localparam scan_state_e NEXT_BIT_ST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    scan_state_e      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W:0]   remaining_q, remaining_d;
    logic [SEL_W:0]   rem_dec;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic              pk_wr;
    logic              pk_clr;
    logic              pk_fill_last;
    logic [WORD_W-1:0] pk_word;

    mux_scan_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (pk_wr),
        .wr_bit    (y),
        .clr       (pk_clr),
        .word      (pk_word),
        .fill_last (pk_fill_last)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .parity    (out_parity)
`endif
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        remaining_d  = remaining_q;
        settle_cnt_d = settle_cnt_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        done_d       = 1'b0;
        pk_wr        = 1'b0;
        pk_clr       = 1'b0;
        rem_dec      = remaining_q - 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        sel_d        = base;
                        remaining_d  = len;
                        settle_cnt_d = '0;
                        state_d      = NEXT_BIT_ST;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    settle_cnt_d = '0;
                    state_d      = ST_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                pk_wr       = 1'b1;
                remaining_d = rem_dec;
                sel_d       = sel_q + 1'b1;
                if (pk_fill_last || (rem_dec == '0)) begin
                    state_d     = ST_EMIT;
                    out_valid_d = 1'b1;
                    out_last_d  = (rem_dec == '0);
                end else begin
                    state_d = NEXT_BIT_ST;
                end
            end
            ST_EMIT: begin
                // Word, last flag and sel are frozen until the consumer takes the word.
                if (out_ready) begin
                    pk_clr      = 1'b1;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (remaining_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = NEXT_BIT_ST;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            remaining_q  <= '0;
            settle_cnt_q <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            remaining_q  <= remaining_d;
            settle_cnt_q <= settle_cnt_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sel       = sel_q;
    assign out_data  = pk_word;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one instance with SETTLE=0 and one with SETTLE=3 share the stimulus.
// The SETTLE=3 instance sees an inverted mux output until sel has been stable for 3 cycles.
module tb_mux_scan_ctrl;

    localparam int WW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base = '0;
    logic [16:0] len = '0;
    logic        out_ready = 1'b1;

    logic [15:0] a_sel, b_sel;
    logic        a_y;
    logic        b_y = 1'b0;
    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid, a_last, b_last, a_busy, b_busy, a_done, b_done;
    logic        a_par, b_par;

    logic        mem [0:65535];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_n_a = 0, done_n_b = 0, done_cyc_a = 0, done_cyc_b = 0;
    int hs_first_a = -1, hs_last_a = -1;
    int stab_b = 0;
    logic [15:0] prev_a = '0, prev_b = '0;

    logic [9:0]  exp_q[$];
    logic [9:0]  got_a[$];
    logic [9:0]  got_b[$];
    logic [15:0] sel_log_a[$];

    mux_scan_ctrl #(.SEL_W(16), .WORD_W(WW), .SETTLE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
        .sel(a_sel), .y(a_y), .out_data(a_data), .out_valid(a_valid),
        .out_ready(out_ready), .out_last(a_last), .busy(a_busy), .done(a_done)
`ifdef MUX_SCAN_PARITY_EN
        , .out_parity(a_par)
`endif
    );

    mux_scan_ctrl #(.SEL_W(16), .WORD_W(WW), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
        .sel(b_sel), .y(b_y), .out_data(b_data), .out_valid(b_valid),
        .out_ready(out_ready), .out_last(b_last), .busy(b_busy), .done(b_done)
`ifdef MUX_SCAN_PARITY_EN
        , .out_parity(b_par)
`endif
    );

`ifndef MUX_SCAN_PARITY_EN
    assign a_par = 1'b0;
    assign b_par = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign a_y = mem[a_sel];

    // Observation point away from the active edge.
    always @(negedge clk) begin
        if (a_valid && out_ready) begin
            got_a.push_back({a_par, a_last, a_data});
            if (hs_first_a < 0) hs_first_a = cyc;
            hs_last_a = cyc;
        end
        if (b_valid && out_ready) got_b.push_back({b_par, b_last, b_data});
        if (a_done) begin done_n_a++; done_cyc_a = cyc; end
        if (b_done) begin done_n_b++; done_cyc_b = cyc; end
        if (a_sel != prev_a) begin sel_log_a.push_back(a_sel); prev_a = a_sel; end
        if (b_sel != prev_b) begin stab_b = 0; prev_b = b_sel; end
        else if (stab_b < 100) stab_b++;
        b_y = (stab_b >= 3) ? mem[b_sel] : ~mem[b_sel];
    end

    // Expected word stream: bit i of the scan is mem[base+i], packed LSB-first, last on the final word.
    task automatic build_exp(input logic [15:0] b, input logic [16:0] l);
        logic [7:0] w;
        logic       p;
        exp_q.delete();
        for (int i = 0; i < int'(l); i += WW) begin
            w = '0;
            for (int k = 0; k < WW; k++)
                if (i + k < int'(l)) w[k] = mem[16'(int'(b) + i + k)];
`ifdef MUX_SCAN_PARITY_EN
            p = ^w;
`else
            p = 1'b0;
`endif
            exp_q.push_back({p, (i + WW >= int'(l)), w});
        end
    endtask

    task automatic clear_obs();
        got_a.delete(); got_b.delete(); sel_log_a.delete();
        hs_first_a = -1; hs_last_a = -1;
        done_n_a = 0; done_n_b = 0;
    endtask

    task automatic do_scan(input logic [15:0] b, input logic [16:0] l, input bit rnd_ready,
                           output bit timed_out);
        int n;
        build_exp(b, l);
        out_ready = 1'b1;
        @(posedge clk); #2;
        clear_obs();
        base = b; len = l; start = 1'b1; start_cyc = cyc;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0;
        while ((done_n_a == 0 || done_n_b == 0) && n < 3000) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #2;
            n++;
        end
        timed_out = (n >= 3000);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        $display("[TB] scan base=%h len=%0d words_a=%0d words_b=%0d", b, l, got_a.size(), got_b.size());
    endtask

    task automatic test_reset();
        logic [28:0] va, vb;
        #1 rst_n = 1'b0;
        #3;
        va = {a_sel, a_data, a_valid, a_last, a_busy, a_done, a_par};
        vb = {b_sel, b_data, b_valid, b_last, b_busy, b_done, b_par};
        tests++; if (va !== '0) begin fails++; $display("FAIL reset_in_a got %h exp 0", va); end
        tests++; if (vb !== '0) begin fails++; $display("FAIL reset_in_b got %h exp 0", vb); end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        va = {a_sel, a_data, a_valid, a_last, a_busy, a_done, a_par};
        vb = {b_sel, b_data, b_valid, b_last, b_busy, b_done, b_par};
        tests++; if (va !== '0) begin fails++; $display("FAIL reset_out_a got %h exp 0", va); end
        tests++; if (vb !== '0) begin fails++; $display("FAIL reset_out_b got %h exp 0", vb); end
    endtask

    task automatic test_basic();
        logic [15:0] pat;
        bit to;
        pat = 16'hA5C3;
        for (int k = 0; k < 16; k++) mem[k] = pat[k];
        do_scan(16'h0000, 17'd16, 1'b0, to);
        tests++; if (to) begin fails++; $display("FAIL basic_timeout got timeout exp done"); end
        tests++; if (got_a.size() != 2 || got_a[0][8:0] !== 9'h0C3 || got_a[1][8:0] !== 9'h1A5) begin
            fails++; $display("FAIL basic_words_a got n=%0d %p exp C3 then A5 last", got_a.size(), got_a); end
        foreach (exp_q[i]) if (i < got_a.size()) begin
            tests++; if (got_a[i] !== exp_q[i]) begin fails++; $display("FAIL basic_word_a[%0d] got %h exp %h", i, got_a[i], exp_q[i]); end end
        tests++; if (got_b.size() != exp_q.size()) begin fails++; $display("FAIL basic_count_b got %0d exp %0d", got_b.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_b.size()) begin
            tests++; if (got_b[i] !== exp_q[i]) begin fails++; $display("FAIL basic_word_b[%0d] got %h exp %h", i, got_b[i], exp_q[i]); end end
        tests++; if (hs_first_a != start_cyc + WW + 1) begin fails++; $display("FAIL basic_first_word_latency got %0d exp %0d", hs_first_a - start_cyc, WW + 1); end
        tests++; if (done_cyc_a != hs_last_a + 1 || done_n_a != 1) begin fails++; $display("FAIL basic_done_a got cyc %0d n %0d exp cyc %0d n 1", done_cyc_a, done_n_a, hs_last_a + 1); end
        tests++; if (done_cyc_a != start_cyc + 19) begin fails++; $display("FAIL basic_done_time_a got %0d exp %0d", done_cyc_a - start_cyc, 19); end
        tests++; if (done_cyc_b != start_cyc + 67) begin fails++; $display("FAIL basic_done_time_b got %0d exp %0d", done_cyc_b - start_cyc, 67); end
        tests++; if (a_sel !== 16'h0010 || b_sel !== 16'h0010) begin fails++; $display("FAIL basic_sel_end got %h/%h exp 0010", a_sel, b_sel); end
        tests++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end got %b/%b exp 0", a_busy, b_busy); end
    endtask

    task automatic test_partial();
        bit to;
        mem[16'h0100] = 1'b1; mem[16'h0101] = 1'b0; mem[16'h0102] = 1'b1;
        mem[16'h0103] = 1'b1; mem[16'h0104] = 1'b1;
        do_scan(16'h0100, 17'd5, 1'b0, to);
        tests++; if (to) begin fails++; $display("FAIL partial_timeout got timeout exp done"); end
        tests++; if (got_a.size() != 1 || got_a[0][8:0] !== 9'h11D) begin fails++; $display("FAIL partial_word_a got n=%0d %p exp 1 word 1D last", got_a.size(), got_a); end
        tests++; if (got_b.size() != 1 || got_b[0] !== exp_q[0]) begin fails++; $display("FAIL partial_word_b got %p exp %p", got_b, exp_q); end
        tests++; if (got_a.size() == 1 && got_a[0] !== exp_q[0]) begin fails++; $display("FAIL partial_parity_a got %h exp %h", got_a[0], exp_q[0]); end
        tests++; if (a_sel !== 16'h0105) begin fails++; $display("FAIL partial_sel_end got %h exp 0105", a_sel); end
    endtask

    task automatic test_wrap();
        bit to;
        do_scan(16'hFFFC, 17'd8, 1'b0, to);
        tests++; if (to) begin fails++; $display("FAIL wrap_timeout got timeout exp done"); end
        tests++; if (sel_log_a.size() != 9) begin fails++; $display("FAIL wrap_sel_count got %0d exp 9", sel_log_a.size()); end
        for (int i = 0; i < 9 && i < sel_log_a.size(); i++) begin
            tests++; if (sel_log_a[i] !== 16'(32'hFFFC + i)) begin fails++; $display("FAIL wrap_sel[%0d] got %h exp %h", i, sel_log_a[i], 16'(32'hFFFC + i)); end end
        tests++; if (got_a.size() != 1 || got_a[0] !== exp_q[0]) begin fails++; $display("FAIL wrap_word_a got %p exp %p", got_a, exp_q); end
        tests++; if (got_b.size() != 1 || got_b[0] !== exp_q[0]) begin fails++; $display("FAIL wrap_word_b got %p exp %p", got_b, exp_q); end
        tests++; if (a_sel !== 16'h0004 || b_sel !== 16'h0004) begin fails++; $display("FAIL wrap_sel_end got %h/%h exp 0004", a_sel, b_sel); end
    endtask

    task automatic test_backpressure();
        logic [15:0] b0, hold_s;
        logic [7:0]  hold_d;
        int n;
        b0 = 16'($urandom);
        build_exp(b0, 17'd8);
        @(posedge clk); #2;
        clear_obs();
        out_ready = 1'b0;
        base = b0; len = 17'd8; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0;
        while (!a_valid && n < 100) begin @(posedge clk); #2; n++; end
        tests++; if (a_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_timeout got %b exp 1", a_valid); end
        hold_d = a_data; hold_s = a_sel;
        repeat (5) begin
            @(negedge clk);
            tests++;
            if (a_valid !== 1'b1 || a_data !== hold_d || a_sel !== hold_s) begin
                fails++; $display("FAIL bp_hold got v=%b d=%h s=%h exp v=1 d=%h s=%h", a_valid, a_data, a_sel, hold_d, hold_s); end
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(posedge clk); #2;
        tests++; if (got_a.size() != 1 || hs_first_a != cyc - 1 || a_valid !== 1'b0) begin
            fails++; $display("FAIL bp_accept got n=%0d hs=%0d v=%b exp n=1 hs=%0d v=0", got_a.size(), hs_first_a, a_valid, cyc - 1); end
        tests++; if (got_a.size() != 1 || got_a[0] !== exp_q[0]) begin fails++; $display("FAIL bp_word_a got %p exp %p", got_a, exp_q); end
        n = 0;
        while (done_n_b == 0 && n < 500) begin @(posedge clk); #2; n++; end
        tests++; if (got_b.size() != 1 || got_b[0] !== exp_q[0]) begin fails++; $display("FAIL bp_word_b got %p exp %p", got_b, exp_q); end
        tests++; if (a_sel !== 16'(b0 + 16'd8)) begin fails++; $display("FAIL bp_sel_end got %h exp %h", a_sel, 16'(b0 + 16'd8)); end
    endtask

    task automatic test_edges();
        logic [15:0] hold_s;
        logic [28:0] va, vb;
        bit to;
        int n;
        // Zero-length request
        @(posedge clk); #2;
        clear_obs();
        hold_s = a_sel;
        base = 16'h1234; len = '0; start = 1'b1; start_cyc = cyc;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        tests++; if (got_a.size() != 0 || got_b.size() != 0) begin fails++; $display("FAIL len0_words got %0d/%0d exp 0", got_a.size(), got_b.size()); end
        tests++; if (done_n_a != 1 || done_cyc_a - start_cyc > 2 || done_n_b != 1) begin
            fails++; $display("FAIL len0_done got n=%0d/%0d dt=%0d exp n=1 dt<=2", done_n_a, done_n_b, done_cyc_a - start_cyc); end
        tests++; if (a_sel !== hold_s) begin fails++; $display("FAIL len0_sel got %h exp %h", a_sel, hold_s); end

        // Start while busy
        for (int k = 0; k < 16; k++) mem[16'h2000 + k] = 1'($urandom);
        build_exp(16'h2000, 17'd16);
        @(posedge clk); #2;
        clear_obs();
        base = 16'h2000; len = 17'd16; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        base = 16'h3000; len = 17'd4; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0;
        while ((done_n_a == 0 || done_n_b == 0) && n < 500) begin @(posedge clk); #2; n++; end
        repeat (3) @(posedge clk);
        #2;
        tests++; if (got_a.size() != 2 || got_a[0] !== exp_q[0] || got_a[1] !== exp_q[1]) begin
            fails++; $display("FAIL busy_start_words_a got %p exp %p", got_a, exp_q); end
        tests++; if (done_n_a != 1 || a_sel !== 16'h2010 || b_sel !== 16'h2010) begin
            fails++; $display("FAIL busy_start_end got n=%0d sel=%h/%h exp n=1 sel=2010", done_n_a, a_sel, b_sel); end

        // Reset mid-word, then a normal scan
        @(posedge clk); #2;
        clear_obs();
        base = 16'h4000; len = 17'd16; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        va = {a_sel, a_data, a_valid, a_last, a_busy, a_done, a_par};
        vb = {b_sel, b_data, b_valid, b_last, b_busy, b_done, b_par};
        tests++; if (va !== '0 || vb !== '0) begin fails++; $display("FAIL midreset_outputs got %h/%h exp 0", va, vb); end
        tests++; if (got_a.size() != 0) begin fails++; $display("FAIL midreset_partial got %0d words exp 0", got_a.size()); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        do_scan(16'h4000, 17'd16, 1'b1, to);
        tests++; if (to) begin fails++; $display("FAIL postreset_timeout got timeout exp done"); end
        tests++; if (got_a.size() != 2 || got_a[0] !== exp_q[0] || got_a[1] !== exp_q[1]) begin
            fails++; $display("FAIL postreset_words_a got %p exp %p", got_a, exp_q); end
        tests++; if (got_b.size() != 2 || got_b[0] !== exp_q[0] || got_b[1] !== exp_q[1]) begin
            fails++; $display("FAIL postreset_words_b got %p exp %p", got_b, exp_q); end
    endtask

    task automatic test_settle();
        bit to;
        for (int k = 0; k < 16; k++) mem[k] = 1'($urandom);
        do_scan(16'h0000, 17'd16, 1'b0, to);
        tests++; if (to) begin fails++; $display("FAIL settle_timeout got timeout exp done"); end
        tests++; if (got_b.size() != exp_q.size()) begin fails++; $display("FAIL settle_count_b got %0d exp %0d", got_b.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_b.size()) begin
            tests++; if (got_b[i] !== exp_q[i]) begin fails++; $display("FAIL settle_word_b[%0d] got %h exp %h", i, got_b[i], exp_q[i]); end end
        tests++; if (done_cyc_b != start_cyc + 1 + 16 * 4 + 2) begin fails++; $display("FAIL settle_done_time got %0d exp %0d", done_cyc_b - start_cyc, 67); end
    endtask

    task automatic test_random();
        bit to;
        logic [15:0] b0;
        logic [16:0] l0;
        for (int it = 0; it < 8; it++) begin
            b0 = 16'($urandom);
            l0 = 17'($urandom_range(1, 40));
            for (int k = 0; k < int'(l0); k++) mem[16'(int'(b0) + k)] = 1'($urandom);
            do_scan(b0, l0, 1'b1, to);
            tests++; if (to) begin fails++; $display("FAIL rand%0d_timeout got timeout exp done", it); end
            tests++; if (got_a.size() != exp_q.size() || got_b.size() != exp_q.size()) begin
                fails++; $display("FAIL rand%0d_count got %0d/%0d exp %0d", it, got_a.size(), got_b.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got_a.size() && i < got_b.size()) begin
                tests++; if (got_a[i] !== exp_q[i] || got_b[i] !== exp_q[i]) begin
                    fails++; $display("FAIL rand%0d_word[%0d] got %h/%h exp %h", it, i, got_a[i], got_b[i], exp_q[i]); end end
            tests++; if (a_sel !== 16'(b0 + l0) || b_sel !== 16'(b0 + l0)) begin
                fails++; $display("FAIL rand%0d_sel_end got %h/%h exp %h", it, a_sel, b_sel, 16'(b0 + l0)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 1'($urandom);
        test_reset();
        test_basic();
        test_partial();
        test_wrap();
        test_backpressure();
        test_edges();
        test_settle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish exp finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
